// File: rtl/sort_mem.sv
// sort_mem: word array with read, write, swap and compare-swap commands.
// All state advances on the falling clock edge; reset clears the array.
module sort_mem #(
    parameter int WORD_SIZE  = 16,
    parameter int DEPTH      = 4096,
    parameter int ADDR_WIDTH = 12,
    parameter int SIGNED_CMP = 0
) (
    input  logic                  clk,
    input  logic                  RST_N,
    input  logic                  CMD_VALID,
    input  logic [1:0]            CMD,
    input  logic [ADDR_WIDTH-1:0] ADDR_A,
    input  logic [ADDR_WIDTH-1:0] ADDR_B,
    input  logic [WORD_SIZE-1:0]  IN,
    output logic                  READY,
    output logic [WORD_SIZE-1:0]  OUT_A,
    output logic [WORD_SIZE-1:0]  OUT_B,
    output logic                  OUT_VALID,
    output logic                  SWAPPED,
    output logic                  BUSY
);

    localparam logic [1:0] CMD_READ  = 2'b00;
    localparam logic [1:0] CMD_WRITE = 2'b01;
    localparam logic [1:0] CMD_SWAP  = 2'b10;
    localparam logic [1:0] CMD_CSWAP = 2'b11;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_CLEAR = 2'b00,
        S_IDLE  = 2'b01,
        S_SW1   = 2'b10,
        S_SW2   = 2'b11
    } state_t;

    logic [WORD_SIZE-1:0] mem [DEPTH];

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] cnt_q;
    logic [WORD_SIZE-1:0]  ta_q;
    logic [WORD_SIZE-1:0]  tb_q;
    logic [ADDR_WIDTH-1:0] addr_a_q;
    logic [ADDR_WIDTH-1:0] addr_b_q;
    logic                  do_swap_q;
    logic [WORD_SIZE-1:0]  out_a_q;
    logic [WORD_SIZE-1:0]  out_b_q;
    logic                  out_valid_q;
    logic                  swapped_q;

    logic [WORD_SIZE-1:0]  rd_a;
    logic [WORD_SIZE-1:0]  rd_b;
    logic                  a_gt_b;
    logic                  do_swap_d;
    logic                  accept;

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [WORD_SIZE-1:0]  mem_wdata;

    // Two asynchronous read ports feed the registered outputs and temporaries.
    assign rd_a = mem[ADDR_A];
    assign rd_b = mem[ADDR_B];

    assign READY     = (state_q == S_IDLE);
    assign BUSY      = (state_q == S_CLEAR);
    assign accept    = CMD_VALID && READY;
    assign OUT_A     = out_a_q;
    assign OUT_B     = out_b_q;
    assign OUT_VALID = out_valid_q;
    assign SWAPPED   = swapped_q;

    // Compare the two read words in the configured number format.
    always_comb begin
        a_gt_b = 1'b0;
        if (SIGNED_CMP != 0) begin
            a_gt_b = $signed(rd_a) > $signed(rd_b);
        end else begin
            a_gt_b = rd_a > rd_b;
        end
    end

    // Swap decision: SWAP always exchanges, CSWAP only when out of order;
    // a self-swap never writes so the word is trivially preserved.
    always_comb begin
        do_swap_d = (CMD == CMD_SWAP) ? 1'b1 : a_gt_b;
        if (ADDR_A == ADDR_B) begin
            do_swap_d = 1'b0;
        end
    end

    // Single write port arbitration: clear sweep, WRITE, or swap halves.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = cnt_q;
        mem_wdata = '0;
        if (RST_N) begin
            case (state_q)
                S_CLEAR: begin
                    mem_we    = 1'b1;
                    mem_waddr = cnt_q;
                    mem_wdata = '0;
                end
                S_IDLE: begin
                    if (accept && CMD == CMD_WRITE) begin
                        mem_we    = 1'b1;
                        mem_waddr = ADDR_A;
                        mem_wdata = IN;
                    end
                end
                S_SW1: begin
                    mem_we    = do_swap_q;
                    mem_waddr = addr_a_q;
                    mem_wdata = tb_q;
                end
                S_SW2: begin
                    mem_we    = do_swap_q;
                    mem_waddr = addr_b_q;
                    mem_wdata = ta_q;
                end
                default: begin
                    mem_we = 1'b0;
                end
            endcase
        end
    end

    // Array storage, written at most once per falling edge.
    always_ff @(negedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Swap operands and addresses are captured when the command is taken.
    always_ff @(negedge clk) begin
        if (state_q == S_IDLE && accept && CMD[1]) begin
            ta_q      <= rd_a;
            tb_q      <= rd_b;
            addr_a_q  <= ADDR_A;
            addr_b_q  <= ADDR_B;
            do_swap_q <= do_swap_d;
        end
    end

    // Control FSM with registered result outputs; reset drops any pending swap.
    always_ff @(negedge clk) begin
        if (!RST_N) begin
            state_q     <= S_CLEAR;
            cnt_q       <= '0;
            out_a_q     <= '0;
            out_b_q     <= '0;
            out_valid_q <= 1'b0;
            swapped_q   <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                S_CLEAR: begin
                    if (cnt_q == LAST_ADDR) begin
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + ADDR_WIDTH'(1);
                    end
                end
                S_IDLE: begin
                    if (accept) begin
                        case (CMD)
                            CMD_READ: begin
                                out_a_q     <= rd_a;
                                out_b_q     <= rd_b;
                                out_valid_q <= 1'b1;
                                swapped_q   <= 1'b0;
                            end
                            CMD_SWAP, CMD_CSWAP: begin
                                state_q <= S_SW1;
                            end
                            default: begin
                                state_q <= S_IDLE;
                            end
                        endcase
                    end
                end
                S_SW1: begin
                    state_q <= S_SW2;
                end
                S_SW2: begin
                    out_a_q     <= ta_q;
                    out_b_q     <= tb_q;
                    swapped_q   <= do_swap_q;
                    out_valid_q <= 1'b1;
                    state_q     <= S_IDLE;
                end
                default: begin
                    state_q <= S_CLEAR;
                end
            endcase
        end
    end

endmodule
